seq_alu: RTL
============

# seq_alu

Parametrised, multi-cycle successor to the single-cycle datapath ALU. Executes the logic/arithmetic ops in one registered cycle and adds an iterative unsigned multiplier and divider that hold the unit busy for WIDTH cycles. Results, comparison flags and a HI register are held until the next accepted operation. Sits in the execute stage; the controller stalls on `busy`.

## Interface
- `WIDTH`, 16: operand/result width (≥4).
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only when `busy`=0.
- `aluoperation`  in  4: op code, sampled with `start`.
- `data1`, `data2`  in  WIDTH each: operands, sampled with `start`.
- `result`  out  WIDTH: registered result (LO half for MUL, quotient for DIV).
- `hi`  out  WIDTH: MUL upper product / DIV remainder; 0 for other ops.
- `zero`, `lt`, `gt`  out  1 each: unsigned compare of captured data1 vs data2.
- `busy`  out  1: high from the cycle after a MUL/DIV accept until its `done`.
- `done`  out  1: one-cycle pulse when `result`/`hi`/flags update.

## Operation
- Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 XNOR, 0110 SLT (unsigned, result 1/0), 1000 MUL, 1001 DIV; all others behave as ADD.
- ADD/SUB wrap modulo 2^WIDTH; no carry/overflow outputs.
- Flags: exactly one of `zero` (equal), `lt`, `gt` high after the first completion; updated on the same edge as `result`.
- MUL: unsigned shift-add, one partial product per cycle, 2·WIDTH product split `hi`:`result`.
- DIV: unsigned restoring, one quotient bit per cycle; quotient → `result`, remainder → `hi`.
- Divide by zero: no iteration; `result` = all ones, `hi` = data1, completes like a single-cycle op.
- FSM: IDLE → (start, MUL) MUL; IDLE → (start, DIV, data2≠0) DIV; other accepted ops stay in IDLE. MUL/DIV → IDLE after iteration WIDTH, asserting `done`.
- `start` while `busy` is ignored; operands are not re-sampled.
- Reset values: `result`=0, `hi`=0, `zero`=`lt`=`gt`=0, `busy`=0, `done`=0, state IDLE.
- `rst` mid-MUL/DIV: operation abandoned, no `done`, all outputs to reset values next edge.

## Timing
- Single-cycle ops (incl. DIV by zero): `start` at edge N → `result`/flags valid and `done`=1 after edge N+1; `busy` never asserts.
- MUL/DIV: `busy`=1 cycles N+1..N+WIDTH; `done`=1 and results valid after edge N+WIDTH; `busy`=0 in the same cycle as `done`.
- A new `start` is accepted in the `done` cycle (back-to-back issue; throughput WIDTH cycles per MUL/DIV).
- Outputs hold between `done` pulses; intermediate iteration values never appear on `result`/`hi`.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV datapath, DIV state and divide-by-zero handling compiled in.
- Undefined: no divider logic; 1001 executes as ADD (single-cycle, `hi`=0). MUL is always present.

## Structure
- `alu_pkg`: op-code localparams (ALU_ADD … ALU_DIV), FSM state enum (IDLE, MUL, DIV).
- One sub-module, `seq_muldiv`: shared shift register/adder iterating MUL and DIV, with `go`/`is_div`/`fin` handshake; flag and single-cycle logic stay in `seq_alu`.

## Test plan (WIDTH=16)
- ADD 0x0005, 0x0003 → `result`=0x0008, `gt`=1, `done` one cycle after `start`, `busy` stays 0; SUB 0x0000−0x0001 → 0xFFFF, `lt`=1.
- SLT 3, 5 → `result`=1, `lt`=1; SLT 7, 7 → `result`=0, `zero`=1.
- MUL 0x1234 × 0x0100 → `hi`=0x0012, `result`=0x3400, `done` 16 cycles after `start`; MUL 0xFFFF × 0xFFFF → `hi`=0xFFFE, `result`=0x0001.
- DIV 100 / 7 → `result`=14, `hi`=2 after 16 cycles; DIV 0x1234 / 0 → `result`=0xFFFF, `hi`=0x1234, `done` after 1 cycle.
- `start` ADD while MUL busy → ignored, MUL result unchanged; new `start` in `done` cycle accepted.
- `rst` at cycle 5 of a MUL → `busy`=0, all outputs 0, no `done` pulse; next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and controller state encoding for seq_alu and seq_muldiv.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_XNOR = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_MUL  = 4'b1000;
   localparam logic [3:0] ALU_DIV  = 4'b1001;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Divider path only present when SEQ_ALU_DIV_EN is defined.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
`ifdef SEQ_ALU_DIV_EN
   input  logic             is_div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fin,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int unsigned CW = $clog2(WIDTH);
`ifdef SEQ_ALU_DIV_EN
   localparam int unsigned AW = WIDTH + 2;
`else
   localparam int unsigned AW = WIDTH + 1;
`endif

   logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] cur_acc, cur_lo;
   logic [AW-1:0]    add_a, add_b, sum;
   logic             add_cin;
`ifdef SEQ_ALU_DIV_EN
   logic             div_q, div_d, cur_div, ge;
`endif

   assign fin = (cnt_q == CW'(WIDTH - 1));

   // The first step runs on the accept edge straight from the operands, so the
   // final step lands exactly WIDTH edges after go.
   always_comb begin
      cur_acc = go ? '0 : acc_q;
      cur_lo  = go ? a  : lo_q;
      b_d     = go ? b  : b_q;
      add_a   = AW'(cur_acc);
      add_b   = cur_lo[0] ? AW'(b_d) : '0;
      add_cin = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_d   = go ? is_div : div_q;
      cur_div = div_d;
      if (cur_div) begin
         add_a   = {1'b0, cur_acc, cur_lo[WIDTH-1]};
         add_b   = ~AW'(b_d);
         add_cin = 1'b1;
      end
`endif
      sum    = add_a + add_b + AW'(add_cin);
      acc_d  = sum[WIDTH:1];
      lo_d   = {sum[0], cur_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      ge = ~sum[AW-1];
      if (cur_div) begin
         acc_d = ge ? sum[WIDTH-1:0] : {cur_acc[WIDTH-2:0], cur_lo[WIDTH-1]};
         lo_d  = {cur_lo[WIDTH-2:0], ge};
      end
`endif
      if (go) begin
         cnt_d = CW'(1);
      end else if (cnt_q != '0) begin
         cnt_d = fin ? '0 : cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
      res_lo = lo_d;
      res_hi = acc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
         div_q <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         if (go || cnt_q != '0) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
`ifdef SEQ_ALU_DIV_EN
            div_q <= div_d;
`endif
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: registered single-cycle ops plus iterative MUL/DIV.
// DIV support is compiled in only when SEQ_ALU_DIV_EN is defined.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       aluoperation,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             lt,
   output logic             gt,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, alu_res;
   logic [2:0]       flags_q, flags_d, pend_q, pend_d, cmp;
   logic             done_q, done_d;
   logic             md_go, md_fin;
   logic [WIDTH-1:0] md_lo, md_hi;
`ifdef SEQ_ALU_DIV_EN
   logic             md_is_div;
`endif

   seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .go     (md_go),
`ifdef SEQ_ALU_DIV_EN
      .is_div (md_is_div),
`endif
      .a      (data1),
      .b      (data2),
      .fin    (md_fin),
      .res_lo (md_lo),
      .res_hi (md_hi)
   );

   // {zero, lt, gt}
   assign cmp = {data1 == data2, data1 < data2, data1 > data2};

   always_comb begin
      unique case (aluoperation)
         ALU_SUB:  alu_res = data1 - data2;
         ALU_AND:  alu_res = data1 & data2;
         ALU_OR:   alu_res = data1 | data2;
         ALU_XOR:  alu_res = data1 ^ data2;
         ALU_XNOR: alu_res = ~(data1 ^ data2);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, data1 < data2};
         default:  alu_res = data1 + data2;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      hi_d     = hi_q;
      flags_d  = flags_q;
      pend_d   = pend_q;
      done_d   = 1'b0;
      md_go    = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      md_is_div = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (aluoperation == ALU_MUL) begin
                  md_go   = 1'b1;
                  pend_d  = cmp;
                  state_d = MUL;
               end
`ifdef SEQ_ALU_DIV_EN
               else if (aluoperation == ALU_DIV) begin
                  if (data2 != '0) begin
                     md_go     = 1'b1;
                     md_is_div = 1'b1;
                     pend_d    = cmp;
                     state_d   = DIV;
                  end else begin
                     result_d = '1;
                     hi_d     = data1;
                     flags_d  = cmp;
                     done_d   = 1'b1;
                  end
               end
`endif
               else begin
                  result_d = alu_res;
                  hi_d     = '0;
                  flags_d  = cmp;
                  done_d   = 1'b1;
               end
            end
         end
         MUL, DIV: begin
            // Flags were captured at accept because the operands are consumed by iteration.
            if (md_fin) begin
               result_d = md_lo;
               hi_d     = md_hi;
               flags_d  = pend_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         hi_q     <= '0;
         flags_q  <= '0;
         pend_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         flags_q  <= flags_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign hi     = hi_q;
   assign zero   = flags_q[2];
   assign lt     = flags_q[1];
   assign gt     = flags_q[0];
   assign busy   = (state_q != IDLE);
   assign done   = done_q;

endmodule
